// File: rtl/rgb_seq_pkg.sv
// Shared constants and state encoding for the RGB fade sequencer.
// Holds duty width, palette geometry and the r/g/b field positions in wr_data.
package rgb_seq_pkg;
    localparam int DUTY_W    = 8;
    localparam int ADDR_W    = 2;
    localparam int N_ENTRIES = 4;
    localparam int COLOR_W   = 3 * DUTY_W;
    localparam int R_LSB     = 16;
    localparam int G_LSB     = 8;
    localparam int B_LSB     = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FADE = 2'd1,
        HOLD = 2'd2
    } state_t;
endpackage

// File: rtl/rgb_fade_sequencer_if.sv
// Palette write bus of the RGB fade sequencer.
// Ports: wr_en strobe, wr_addr entry index, wr_data {r,g,b} colour.
interface rgb_fade_sequencer_if;
    import rgb_seq_pkg::*;

    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [COLOR_W-1:0] wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/rgb_channel_stepper.sv
// One colour channel: moves cur one unit toward target when step_en is set.
// Ports: cur, target, step_en in; nxt value and at_target flag out (comb).
module rgb_channel_stepper
    import rgb_seq_pkg::*;
(
    input  logic [DUTY_W-1:0] cur,
    input  logic [DUTY_W-1:0] target,
    input  logic              step_en,
    output logic [DUTY_W-1:0] nxt,
    output logic              at_target
);
    always_comb begin
        at_target = (cur == target);
        nxt       = cur;
        // Only step when unequal, so the value can never wrap.
        if (step_en && !at_target) begin
            nxt = (cur < target) ? cur + 1'b1 : cur - 1'b1;
        end
    end
endmodule

// File: rtl/rgb_fade_sequencer.sv
// Steps through a colour palette, fading linearly between entries and
// holding each colour. Ports: clk, rst, tick, start, stop, palette write
// bus (wr), last_idx in; duty_r/g/b, cur_idx, busy, upd, wrap out.
module rgb_fade_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int STEP_DIV   = 4,
    parameter int HOLD_TICKS = 500
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                start,
    input  logic                stop,
    rgb_fade_sequencer_if.slave wr,
    input  logic [ADDR_W-1:0]   last_idx,
    output logic [DUTY_W-1:0]   duty_r,
    output logic [DUTY_W-1:0]   duty_g,
    output logic [DUTY_W-1:0]   duty_b,
    output logic [ADDR_W-1:0]   cur_idx,
    output logic                busy,
    output logic                upd,
    output logic                wrap
);
    localparam int SW = $clog2(STEP_DIV + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    state_t             state;
    logic [SW-1:0]      step_cnt;
    logic [HW-1:0]      hold_cnt;
    logic [COLOR_W-1:0] palette [N_ENTRIES];

    logic [COLOR_W-1:0] tgt;
    logic [DUTY_W-1:0]  nr, ng, nb;
    logic               at_r, at_g, at_b;
    logic               all_at;
    logic               step_en;
    logic [ADDR_W-1:0]  nxt_idx;

    // Target is read live so a write to the current entry retargets at once.
    assign tgt     = palette[cur_idx];
    assign all_at  = at_r & at_g & at_b;
    assign step_en = (state == FADE) && tick
                   && (step_cnt == SW'(STEP_DIV - 1));
    assign nxt_idx = (cur_idx >= last_idx) ? '0 : cur_idx + 1'b1;

    rgb_channel_stepper u_r (
        .cur       (duty_r),
        .target    (tgt[R_LSB +: DUTY_W]),
        .step_en   (step_en),
        .nxt       (nr),
        .at_target (at_r)
    );

    rgb_channel_stepper u_g (
        .cur       (duty_g),
        .target    (tgt[G_LSB +: DUTY_W]),
        .step_en   (step_en),
        .nxt       (ng),
        .at_target (at_g)
    );

    rgb_channel_stepper u_b (
        .cur       (duty_b),
        .target    (tgt[B_LSB +: DUTY_W]),
        .step_en   (step_en),
        .nxt       (nb),
        .at_target (at_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            step_cnt <= '0;
            hold_cnt <= '0;
            duty_r   <= '0;
            duty_g   <= '0;
            duty_b   <= '0;
            cur_idx  <= '0;
            busy     <= 1'b0;
            upd      <= 1'b0;
            wrap     <= 1'b0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                palette[i] <= '0;
            end
        end else begin
            upd  <= 1'b0;
            wrap <= 1'b0;
            if (wr.wr_en) begin
                palette[wr.wr_addr] <= wr.wr_data;
            end
            if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= FADE;
                            cur_idx  <= '0;
                            step_cnt <= '0;
                            hold_cnt <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    FADE: begin
                        // Arrival is checked before ticks: zero-distance
                        // fades leave after a single clk.
                        if (all_at) begin
                            state    <= HOLD;
                            hold_cnt <= '0;
                        end else if (step_en) begin
                            step_cnt <= '0;
                            duty_r   <= nr;
                            duty_g   <= ng;
                            duty_b   <= nb;
                            upd      <= 1'b1;
                        end else if (tick) begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (tick) begin
                            if (hold_cnt == HW'(HOLD_TICKS - 1)) begin
                                state    <= FADE;
                                cur_idx  <= nxt_idx;
                                wrap     <= (nxt_idx == '0);
                                step_cnt <= '0;
                                hold_cnt <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Self-checking bench for rgb_fade_sequencer against a behavioural model.
// Directed scenarios followed by a randomized palette/tick/control run.
module tb_rgb_fade_sequencer;
    localparam int SD = 3;
    localparam int HT = 6;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       start;
    logic       stop;
    logic [1:0] last_idx;
    logic [7:0] duty_r, duty_g, duty_b;
    logic [1:0] cur_idx;
    logic       busy, upd, wrap;

    rgb_fade_sequencer_if bus ();

    rgb_fade_sequencer #(
        .STEP_DIV   (SD),
        .HOLD_TICKS (HT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .start    (start),
        .stop     (stop),
        .wr       (bus),
        .last_idx (last_idx),
        .duty_r   (duty_r),
        .duty_g   (duty_g),
        .duty_b   (duty_b),
        .cur_idx  (cur_idx),
        .busy     (busy),
        .upd      (upd),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_upd  = 0;
    int n_wrap = 0;

    // Behavioural model: phase name, ticks counted in the phase, colours.
    string       m_phase;
    int          m_ticks;
    int          m_r, m_g, m_b, m_idx;
    int          m_busy, m_upd, m_wrap;
    logic [23:0] m_pal [4];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int toward(int c, int t);
        if (c < t) return c + 1;
        if (c > t) return c - 1;
        return c;
    endfunction

    function automatic void model_reset();
        m_phase = "idle";
        m_ticks = 0;
        m_r = 0; m_g = 0; m_b = 0; m_idx = 0;
        m_busy = 0; m_upd = 0; m_wrap = 0;
        for (int i = 0; i < 4; i++) m_pal[i] = 24'h0;
    endfunction

    function automatic void model_step();
        logic [23:0] t;
        int tr, tg, tb;
        t  = m_pal[m_idx];
        tr = int'(t[23:16]);
        tg = int'(t[15:8]);
        tb = int'(t[7:0]);
        m_upd  = 0;
        m_wrap = 0;
        if (stop) begin
            m_phase = "idle";
            m_busy  = 0;
        end else if (m_phase == "idle") begin
            if (start) begin
                m_phase = "fade";
                m_idx   = 0;
                m_ticks = 0;
                m_busy  = 1;
            end
        end else if (m_phase == "fade") begin
            if (m_r == tr && m_g == tg && m_b == tb) begin
                m_phase = "hold";
                m_ticks = 0;
            end else if (tick) begin
                m_ticks++;
                if (m_ticks == SD) begin
                    m_ticks = 0;
                    m_r = toward(m_r, tr);
                    m_g = toward(m_g, tg);
                    m_b = toward(m_b, tb);
                    m_upd = 1;
                end
            end
        end else begin
            if (tick) begin
                m_ticks++;
                if (m_ticks == HT) begin
                    m_ticks = 0;
                    m_idx   = (m_idx >= int'(last_idx)) ? 0 : m_idx + 1;
                    m_wrap  = (m_idx == 0);
                    m_phase = "fade";
                end
            end
        end
        if (bus.wr_en) m_pal[bus.wr_addr] = bus.wr_data;
    endfunction

    task automatic cmp_all();
        chk("duty_r", duty_r, m_r);
        chk("duty_g", duty_g, m_g);
        chk("duty_b", duty_b, m_b);
        chk("cur_idx", cur_idx, m_idx);
        chk("busy", busy, m_busy);
        chk("upd", upd, m_upd);
        chk("wrap", wrap, m_wrap);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        cmp_all();
        n_upd  += int'(upd);
        n_wrap += int'(wrap);
        start       = 1'b0;
        stop        = 1'b0;
        bus.wr_en   = 1'b0;
    endtask

    task automatic zero_chk(string tag);
        chk({tag, "_r"}, duty_r, 0);
        chk({tag, "_g"}, duty_g, 0);
        chk({tag, "_b"}, duty_b, 0);
        chk({tag, "_idx"}, cur_idx, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_upd"}, upd, 0);
        chk({tag, "_wrap"}, wrap, 0);
    endtask

    task automatic do_reset();
        start = 1'b0; stop = 1'b0; tick = 1'b0;
        bus.wr_en = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        zero_chk("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic write(logic [1:0] a, logic [23:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        cycle();
    endtask

    initial begin
        int cnt;
        int max_r;
        int ok;
        rst = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0;
        last_idx = 2'd0;
        bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 24'h0;
        model_reset();

        // Single entry, no wrap movement.
        do_reset();
        write(2'd0, 24'h100004);
        last_idx = 2'd0;
        tick = 1'b1;
        n_upd = 0; n_wrap = 0;
        start = 1'b1;
        cycle();
        for (int i = 0; i < 200 && m_phase != "hold"; i++) cycle();
        chk("t1_hold_reached", m_phase == "hold", 1);
        chk("t1_r", duty_r, 8'h10);
        chk("t1_g", duty_g, 8'h00);
        chk("t1_b", duty_b, 8'h04);
        chk("t1_upd_count", n_upd, 16);
        for (int i = 0; i < 50 && m_wrap == 0; i++) cycle();
        chk("t1_wrap_count", n_wrap, 1);
        chk("t1_idx", cur_idx, 0);
        for (int i = 0; i < 20; i++) cycle();
        chk("t1_no_more_upd", n_upd, 16);

        // Two entries, full-scale cross fade.
        do_reset();
        write(2'd0, 24'hFF0000);
        write(2'd1, 24'h0000FF);
        last_idx = 2'd1;
        tick = 1'b1;
        start = 1'b1;
        cycle();
        cnt = 0;
        for (int i = 0; i < 2000 && duty_r != 8'hFF; i++) begin
            cycle();
            cnt++;
        end
        chk("t2_fade_ticks", cnt, 255 * SD);
        for (int i = 0; i < 50 && m_idx != 1; i++) cycle();
        chk("t2_idx1", cur_idx, 1);
        ok = 1;
        n_upd = 0;
        for (int i = 0; i < 2000 && !(m_phase == "hold" && m_idx == 1); i++) begin
            cycle();
            if (upd && (int'(duty_r) + int'(duty_b) != 255)) ok = 0;
        end
        chk("t2_lockstep", ok, 1);
        chk("t2_steps", n_upd, 255);
        chk("t2_b_full", duty_b, 8'hFF);
        chk("t2_r_zero", duty_r, 8'h00);
        n_wrap = 0;
        for (int i = 0; i < 50 && m_wrap == 0; i++) cycle();
        chk("t2_wrap", n_wrap, 1);
        chk("t2_idx0", cur_idx, 0);

        // Retarget mid-fade reverses direction.
        do_reset();
        write(2'd0, 24'h800000);
        last_idx = 2'd0;
        tick = 1'b1;
        start = 1'b1;
        cycle();
        for (int i = 0; i < 1000 && m_r != 8'h40; i++) cycle();
        chk("t3_at_40", duty_r, 8'h40);
        write(2'd0, 24'h200000);
        max_r = 0;
        for (int i = 0; i < 1000 && m_phase != "hold"; i++) begin
            cycle();
            if (int'(duty_r) > max_r) max_r = int'(duty_r);
        end
        chk("t3_reversed", max_r <= 8'h41, 1);
        chk("t3_final", duty_r, 8'h20);

        // Stop freezes the outputs.
        do_reset();
        write(2'd0, 24'h800000);
        tick = 1'b1;
        start = 1'b1;
        cycle();
        for (int i = 0; i < 1000 && m_r != 8'h33; i++) cycle();
        stop = 1'b1;
        cycle();
        chk("t4_busy_off", busy, 0);
        for (int i = 0; i < 30; i++) cycle();
        chk("t4_frozen", duty_r, 8'h33);
        start = 1'b1;
        cycle();
        chk("t4_restart_busy", busy, 1);
        chk("t4_restart_idx", cur_idx, 0);

        // Start and stop together, and start while busy.
        stop = 1'b1;
        cycle();
        start = 1'b1; stop = 1'b1;
        cycle();
        chk("t5_stop_wins", busy, 0);
        start = 1'b1;
        cycle();
        for (int i = 0; i < 5; i++) cycle();
        start = 1'b1;
        cycle();
        chk("t5_start_busy", busy, 1);

        // Randomized palette, pacing and control.
        do_reset();
        for (int a = 0; a < 4; a++) begin
            write(2'(a), {8'($urandom_range(0, 24)),
                          8'($urandom_range(0, 24)),
                          8'($urandom_range(0, 24))});
        end
        last_idx = 2'($urandom_range(0, 3));
        start = 1'b1;
        cycle();
        for (int i = 0; i < 6000; i++) begin
            tick = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = 2'($urandom_range(0, 3));
                bus.wr_data = {8'($urandom_range(0, 24)),
                               8'($urandom_range(0, 24)),
                               8'($urandom_range(0, 24))};
            end
            if ($urandom_range(0, 199) == 0) last_idx = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) start = 1'b1;
            if ($urandom_range(0, 399) == 0) stop = 1'b1;
            cycle();
        end

        // Asynchronous reset mid-hold clears everything, palette included.
        do_reset();
        write(2'd0, 24'h0A0B0C);
        tick = 1'b1;
        start = 1'b1;
        cycle();
        for (int i = 0; i < 200 && m_phase != "hold"; i++) cycle();
        cycle();
        cycle();
        chk("t7_in_hold", duty_r, 8'h0A);
        #2;
        rst = 1'b1;
        #1;
        zero_chk("t7_async");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b1;
        cycle();
        for (int i = 0; i < 30; i++) cycle();
        chk("t7_pal_r", duty_r, 0);
        chk("t7_pal_g", duty_g, 0);
        chk("t7_pal_b", duty_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
